comp_heartbeat_monitor: RTL and testbench



---
 rtl/hb_pkg.sv | 14 +
 rtl/hb_channel.sv | 89 ++++++++
 rtl/comp_heartbeat_monitor.sv | 47 ++++
 tb/tb_comp_heartbeat_monitor.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// Shared types and defaults for the lab heartbeat monitor.
package hb_pkg;

    // Per-channel presence state: OFF until one heartbeat, PEND until a second, then ON.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PEND = 2'd1,
        ON   = 2'd2
    } hb_state_t;

    localparam int N_COMPS_DEF = 5;
    localparam int TIMEOUT_DEF = 1000;

endpackage

// File: rtl/hb_channel.sv
// One heartbeat line: synchroniser, rising-edge detect, presence FSM and timeout counter.
module hb_channel
    import hb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hb,
    output logic online
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic             sync1_q, sync2_q, prev_q;
    logic             edge_w;
    hb_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             online_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= hb;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A level held high yields exactly one heartbeat.
    assign edge_w = sync2_q & ~prev_q;

    // Presence FSM; an edge always beats a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            online_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    cnt_q    <= '0;
                    online_q <= 1'b0;
                    if (edge_w) state_q <= PEND;
                end
                PEND: begin
                    if (edge_w) begin
                        state_q  <= ON;
                        cnt_q    <= '0;
                        online_q <= 1'b1;
                    end else if (cnt_q == LAST) begin
                        state_q  <= OFF;
                        cnt_q    <= '0;
                        online_q <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        online_q <= 1'b0;
                    end
                end
                ON: begin
                    if (edge_w) begin
                        cnt_q    <= '0;
                        online_q <= 1'b1;
                    end else if (cnt_q == LAST) begin
                        state_q  <= OFF;
                        cnt_q    <= '0;
                        online_q <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        online_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= OFF;
                    cnt_q    <= '0;
                    online_q <= 1'b0;
                end
            endcase
        end
    end

    assign online = online_q;

endmodule

// File: rtl/comp_heartbeat_monitor.sv
// Top: one hb_channel per lab computer, online vector plus a registered change pulse.
module comp_heartbeat_monitor
    import hb_pkg::*;
#(
    parameter int N_COMPS = N_COMPS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_COMPS-1:0] hb,
    output logic [N_COMPS-1:0] comps,
    output logic               change
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [N_COMPS-1:0] online_w;
    logic [N_COMPS-1:0] comps_prev_q;
    logic               change_q;

    for (genvar i = 0; i < N_COMPS; i++) begin : g_ch
        hb_channel #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .hb     (hb[i]),
            .online (online_w[i])
        );
    end

    // Compare against last cycle's vector; any number of toggles gives one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comps_prev_q <= '0;
            change_q     <= 1'b0;
        end else begin
            comps_prev_q <= online_w;
            change_q     <= |(online_w ^ comps_prev_q);
        end
    end

    assign comps  = online_w;
    assign change = change_q;

endmodule

// File: tb/tb_comp_heartbeat_monitor.sv
// Directed bench for comp_heartbeat_monitor with a short timeout.
module tb_comp_heartbeat_monitor;

    localparam int N = 5;
    localparam int TO = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] hb;
    logic [N-1:0] comps;
    logic         change;

    int n_cmp = 0;
    int n_bad = 0;

    comp_heartbeat_monitor #(.N_COMPS(N), .TIMEOUT(TO)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hb     (hb),
        .comps  (comps),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] ec, input logic ech);
        chk({tag, ".comps"}, 32'(comps), 32'(ec));
        chk({tag, ".change"}, 32'(change), 32'(ech));
    endtask

    initial begin
        rst_n = 1'b0;
        hb    = '0;

        // Reset held while all lines toggle: outputs stay quiet.
        for (int i = 0; i < 8; i++) begin
            hb = (i % 2 == 0) ? 5'b11111 : 5'b00000;
            tick();
            chk_out("rst_hold", 5'b00000, 1'b0);
        end
        hb = '0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk_out("post_rst", 5'b00000, 1'b0);

        // Channel 0: first pulse -> PEND only.
        hb[0] = 1'b1;
        tick(2);
        hb[0] = 1'b0;
        tick();
        chk_out("ch0_pend", 5'b00000, 1'b0);
        tick(5);
        // Second pulse 8 cycles after the first.
        hb[0] = 1'b1;
        tick(2);
        hb[0] = 1'b0;
        chk_out("ch0_pre_on", 5'b00000, 1'b0);
        tick();                                   // FSM update edge E
        chk_out("ch0_on", 5'b00001, 1'b0);
        tick();
        chk_out("ch0_on_chg", 5'b00001, 1'b1);
        tick();
        chk_out("ch0_on_chg_end", 5'b00001, 1'b0);

        // Heartbeat whose edge cycle coincides with cnt == TIMEOUT-1.
        tick(11);                                 // E+13
        hb[0] = 1'b1;
        tick(2);                                  // E+15
        hb[0] = 1'b0;
        chk_out("ch0_cnt15", 5'b00001, 1'b0);
        tick();                                   // E+16 = E'
        chk_out("ch0_edge_wins", 5'b00001, 1'b0);

        // Timeout from the new edge cycle: still ON at +15, OFF at +16.
        tick(15);
        chk_out("ch0_to_m1", 5'b00001, 1'b0);
        tick();
        chk_out("ch0_to", 5'b00000, 1'b0);
        tick();
        chk_out("ch0_to_chg", 5'b00000, 1'b1);
        tick();
        chk_out("ch0_to_chg_end", 5'b00000, 1'b0);

        // Channel 3 single pulse: never shows, then must have returned to OFF.
        hb[3] = 1'b1;
        tick(2);
        hb[3] = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            chk_out("ch3_single", 5'b00000, 1'b0);
        end
        // A lone pulse after the timeout must re-enter PEND, not ON.
        hb[3] = 1'b1;
        tick(2);
        hb[3] = 1'b0;
        tick(3);
        chk_out("ch3_repend", 5'b00000, 1'b0);
        tick(20);
        chk_out("ch3_idle", 5'b00000, 1'b0);

        // All channels come ON together: one change pulse.
        hb = 5'b11111;
        tick(2);
        hb = 5'b00000;
        tick(4);
        chk_out("all_pend", 5'b00000, 1'b0);
        hb = 5'b11111;
        tick(2);
        hb = 5'b00000;
        chk_out("all_pre_on", 5'b00000, 1'b0);
        tick();
        chk_out("all_on", 5'b11111, 1'b0);
        tick();
        chk_out("all_on_chg", 5'b11111, 1'b1);
        tick();
        chk_out("all_on_chg_end", 5'b11111, 1'b0);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 5'b00000, 1'b0);
        tick();
        chk_out("async_rst_hold", 5'b00000, 1'b0);
        rst_n = 1'b1;
        tick(3);
        chk_out("after_rst", 5'b00000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
